fetch_queue: RTL and testbench

Instruction fetch queue between instruction memory and the decode pipeline register. It generates sequential fetch addresses and issues them over a request/acknowledge interface to a variable-latency instruction memory. In-order responses are buffered as (pc, instruction) pairs in a FIFO and presented to decode with a valid/stall handshake. Execute-stage redirects flush the queue and discard responses still in flight.

---
 rtl/fetch_queue_if.sv | 29 ++
 rtl/fetch_queue.sv | 102 ++++++++++
 tb/tb_fetch_queue.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/fetch_queue_if.sv
// Fetch queue bus: instruction-memory request/response channel, decode
// handshake and execute-stage redirect, bundled into one interface.
interface fetch_queue_if #(
  parameter int DBITS = 32
);
  logic             redirect;
  logic [DBITS-1:0] redirect_pc;
  logic             imem_req;
  logic [DBITS-1:0] imem_addr;
  logic             imem_ack;
  logic             imem_rvalid;
  logic [DBITS-1:0] imem_rdata;
  logic             dec_valid;
  logic [DBITS-1:0] dec_pc;
  logic [DBITS-1:0] dec_inst;
  logic             dec_stall;

  // fetch queue side
  modport master (
    input  redirect, redirect_pc, imem_ack, imem_rvalid, imem_rdata, dec_stall,
    output imem_req, imem_addr, dec_valid, dec_pc, dec_inst
  );

  // memory / pipeline environment side
  modport slave (
    output redirect, redirect_pc, imem_ack, imem_rvalid, imem_rdata, dec_stall,
    input  imem_req, imem_addr, dec_valid, dec_pc, dec_inst
  );
endinterface

// File: rtl/fetch_queue.sv
// Instruction fetch queue: issues sequential fetch addresses to a
// variable-latency in-order memory, buffers (pc, inst) pairs in a FIFO and
// hands them to decode. A redirect flushes the FIFO and marks every response
// still in flight for discard via the drop counter.
module fetch_queue #(
  parameter int               DBITS     = 32,
  parameter logic [DBITS-1:0] START_PC  = 'h40,
  parameter logic [DBITS-1:0] INST_SIZE = 'd4,
  parameter int               DEPTH     = 4
) (
  input logic        clk,
  input logic        reset,
  fetch_queue_if.master bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW:0] DEPTH_C = (CW + 1)'(DEPTH);

  logic [DBITS-1:0] fetch_pc_q, fetch_pc_d;
  logic [DBITS-1:0] resp_pc_q, resp_pc_d;
  logic [AW-1:0]    rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [CW-1:0]    out_q, out_d;
  logic [CW-1:0]    drop_q, drop_d;
  logic [DBITS-1:0] pc_mem   [DEPTH];
  logic [DBITS-1:0] inst_mem [DEPTH];
  logic [CW:0]      credit;
  logic             issue, accept, push, pop;

  // Next-state: credit-based issue, response push/drop, pop, redirect flush.
  // Outstanding includes responses destined for the drop counter, so credit
  // stays exhausted until stale responses have drained.
  always_comb begin
    credit     = {1'b0, count_q} + {1'b0, out_q};
    issue      = !bus.redirect && (credit < DEPTH_C);
    accept     = issue && bus.imem_ack;
    pop        = (count_q != '0) && !bus.dec_stall && !bus.redirect;
    push       = bus.imem_rvalid && !bus.redirect && (drop_q == '0);
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    rd_d       = rd_q;
    wr_d       = wr_q;
    count_d    = count_q;
    out_d      = out_q;
    drop_d     = drop_q;
    if (bus.redirect) begin
      fetch_pc_d = bus.redirect_pc;
      resp_pc_d  = bus.redirect_pc;
      rd_d       = '0;
      wr_d       = '0;
      count_d    = '0;
      out_d      = out_q - CW'(bus.imem_rvalid);
      drop_d     = out_q - CW'(bus.imem_rvalid);
    end else begin
      if (accept) fetch_pc_d = fetch_pc_q + INST_SIZE;
      if (bus.imem_rvalid && (drop_q != '0)) drop_d = drop_q - CW'(1);
      if (push) begin
        wr_d      = wr_q + AW'(1);
        resp_pc_d = resp_pc_q + INST_SIZE;
      end
      if (pop) rd_d = rd_q + AW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
      out_d   = out_q + CW'(accept) - CW'(bus.imem_rvalid);
    end
  end

  // Control state registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc_q <= START_PC;
      resp_pc_q  <= START_PC;
      rd_q       <= '0;
      wr_q       <= '0;
      count_q    <= '0;
      out_q      <= '0;
      drop_q     <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      rd_q       <= rd_d;
      wr_q       <= wr_d;
      count_q    <= count_d;
      out_q      <= out_d;
      drop_q     <= drop_d;
    end
  end

  // FIFO payload storage; contents are only visible while count is nonzero.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_q]   <= resp_pc_q;
      inst_mem[wr_q] <= bus.imem_rdata;
    end
  end

  // Reset gates the request combinationally so it drops the moment reset asserts.
  assign bus.imem_req  = issue && reset;
  assign bus.imem_addr = fetch_pc_q;
  assign bus.dec_valid = (count_q != '0);
  assign bus.dec_pc    = bus.dec_valid ? pc_mem[rd_q]   : '0;
  assign bus.dec_inst  = bus.dec_valid ? inst_mem[rd_q] : '0;
endmodule

// File: tb/tb_fetch_queue.sv
// Randomized bench for fetch_queue. A memory model answers accepted requests
// in order after a random latency; a reference model tracks fetch PC, queue
// occupancy and which in-flight requests are still live, pushing expected
// (pc, inst) pairs to a scoreboard that a separate monitor consumes.
module tb_fetch_queue;
  localparam int DBITS = 32;
  localparam int DEPTH = 4;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } entry_t;

  typedef struct {
    logic [31:0] addr;
    int          ready;
    bit          live;
  } req_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fetch_queue_if #(.DBITS(DBITS)) bus ();

  fetch_queue #(
    .DBITS(DBITS), .START_PC(32'h40), .INST_SIZE(32'd4), .DEPTH(DEPTH)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  entry_t      sb[$];
  req_t        inflight[$];
  int          checks = 0;
  int          failures = 0;
  int          cyc, occ, last_ready, acc_count;
  logic [31:0] m_pc;
  int          stall_pct, ack_pct, redir_pct, lat_min, lat_max;
  bit          first_chk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every cycle, compare the decode port against the scoreboard head.
  initial begin
    forever begin
      @(negedge clk);
      if (reset === 1'b1) begin
        check("dec_valid", {31'b0, bus.dec_valid}, {31'b0, sb.size() != 0});
        if (sb.size() != 0) begin
          check("dec_pc", bus.dec_pc, sb[0].pc);
          check("dec_inst", bus.dec_inst, sb[0].inst);
          if (!bus.dec_stall && !bus.redirect) void'(sb.pop_front());
        end else begin
          check("dec_pc_idle", bus.dec_pc, 32'h0);
          check("dec_inst_idle", bus.dec_inst, 32'h0);
        end
      end
    end
  end

  task automatic drive();
    bus.redirect = ($urandom_range(99) < redir_pct);
    if ($urandom_range(3) == 0) bus.redirect_pc = 32'hFFFF_FFF8;
    else bus.redirect_pc = {$urandom_range(16'hFFFF), 16'h0} | ($urandom_range(255) << 2);
    bus.imem_ack  = ($urandom_range(99) < ack_pct);
    bus.dec_stall = ($urandom_range(99) < stall_pct);
    if (inflight.size() != 0 && inflight[0].ready <= cyc) begin
      bus.imem_rvalid = 1'b1;
      bus.imem_rdata  = mem_word(inflight[0].addr);
    end else begin
      bus.imem_rvalid = 1'b0;
      bus.imem_rdata  = $urandom;
    end
  endtask

  // One clock of stimulus plus reference-model update.
  task automatic step();
    bit     exp_req, acc, rv, redir, stall, push, pop;
    req_t   r;
    entry_t e;
    int     lat;
    @(negedge clk);
    exp_req = !bus.redirect && ((occ + inflight.size()) < DEPTH);
    check("imem_req", {31'b0, bus.imem_req}, {31'b0, exp_req});
    if (exp_req) check("imem_addr", bus.imem_addr, m_pc);
    if (first_chk && cyc == 2) begin
      check("first_dec_valid", {31'b0, bus.dec_valid}, 32'h1);
      check("first_dec_pc", bus.dec_pc, 32'h40);
      first_chk = 1'b0;
    end
    acc   = exp_req && bus.imem_ack;
    rv    = bus.imem_rvalid;
    redir = bus.redirect;
    stall = bus.dec_stall;
    @(posedge clk);
    pop  = (occ > 0) && !stall && !redir;
    push = 1'b0;
    if (rv) begin
      r = inflight.pop_front();
      if (r.live && !redir) begin
        e.pc   = r.addr;
        e.inst = mem_word(r.addr);
        sb.push_back(e);
        push = 1'b1;
      end
    end
    if (redir) begin
      sb.delete();
      occ = 0;
      foreach (inflight[i]) inflight[i].live = 1'b0;
      m_pc = bus.redirect_pc;
    end else begin
      occ = occ + int'(push) - int'(pop);
    end
    if (acc) begin
      lat = $urandom_range(lat_max, lat_min);
      r.addr  = m_pc;
      r.ready = (cyc + lat > last_ready) ? cyc + lat : last_ready + 1;
      r.live  = 1'b1;
      last_ready = r.ready;
      inflight.push_back(r);
      m_pc = m_pc + 32'd4;
      acc_count++;
    end
    cyc++;
    #1;
    drive();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic set_knobs(input int st, input int ak, input int rd, input int lmin, input int lmax);
    stall_pct = st; ack_pct = ak; redir_pct = rd; lat_min = lmin; lat_max = lmax;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    sb.delete();
    inflight.delete();
    occ = 0; cyc = 0; last_ready = -1; acc_count = 0;
    m_pc = 32'h40;
    bus.redirect = 1'b0; bus.redirect_pc = '0; bus.imem_ack = 1'b0;
    bus.imem_rvalid = 1'b0; bus.imem_rdata = '0; bus.dec_stall = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    drive();
  endtask

  initial begin
    first_chk = 1'b0;
    // Zero-wait memory, no stall: one instruction per cycle from cycle 2.
    set_knobs(0, 100, 0, 1, 1);
    first_chk = 1'b1;
    do_reset();
    run(24);

    // Decode stalled from reset: exactly DEPTH requests accepted, then drain.
    set_knobs(100, 100, 0, 1, 1);
    do_reset();
    run(10);
    check("stall_accepts", acc_count, DEPTH);
    set_knobs(0, 100, 0, 1, 1);
    run(10);

    // Memory refuses for 5 cycles: address held, no skip.
    set_knobs(0, 0, 0, 1, 3);
    run(5);
    set_knobs(0, 100, 0, 1, 3);
    run(10);

    // Fixed 3-cycle latency with redirects landing on outstanding requests.
    set_knobs(0, 100, 15, 3, 3);
    run(200);

    // Fully random traffic.
    set_knobs(30, 70, 8, 1, 3);
    run(3000);

    // Fill the queue under stall, then reset asynchronously mid-stream.
    set_knobs(100, 100, 0, 1, 1);
    run(8);
    reset = 1'b0;
    #1;
    check("rst_dec_valid", {31'b0, bus.dec_valid}, 32'h0);
    check("rst_imem_req", {31'b0, bus.imem_req}, 32'h0);
    set_knobs(0, 100, 0, 1, 1);
    do_reset();
    run(12);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
